guess_checker: RTL and testbench

- Downstream consumer of the per-button one-cycle pulses produced by the button shaping stage (one shaper per game button).
- Walks the stored pattern memory one step at a time and compares each player press against the expected step.
- Reports a round result as a one-cycle pass or fail pulse to the game controller.
- Enforces a per-step response timeout.

---
 rtl/guess_checker_pkg.sv | 19 +
 rtl/guess_checker_btn_encoder.sv | 29 ++
 rtl/guess_checker.sv | 157 +++++++++++++++
 tb/tb_guess_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/guess_checker_pkg.sv
// Shared game definitions: checker state encoding, button codes and default widths.
package guess_checker_pkg;

   localparam int IDX_W_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_LOAD     = 3'd2,
      ST_WAIT_BTN = 3'd3,
      ST_RESULT   = 3'd4
   } state_t;

   localparam logic [1:0] BTN0 = 2'd0;
   localparam logic [1:0] BTN1 = 2'd1;
   localparam logic [1:0] BTN2 = 2'd2;
   localparam logic [1:0] BTN3 = 2'd3;

endpackage

// File: rtl/guess_checker_btn_encoder.sv
// Turns the 4-bit press pulse vector into a button code plus single/multi press flags.
module guess_checker_btn_encoder
   import guess_checker_pkg::*;
(
   input  logic [3:0] i_onehot,
   output logic [1:0] o_code,
   output logic       o_valid,
   output logic       o_multi
);

   logic [3:0] w_low_cleared;

   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign w_low_cleared = i_onehot & (i_onehot - 4'd1);
   assign o_multi       = |w_low_cleared;
   assign o_valid       = (|i_onehot) && !o_multi;

   always_comb begin
      o_code = BTN0;
      case (i_onehot)
         4'b0001: o_code = BTN0;
         4'b0010: o_code = BTN1;
         4'b0100: o_code = BTN2;
         4'b1000: o_code = BTN3;
         default: o_code = BTN0;
      endcase
   end

endmodule

// File: rtl/guess_checker.sv
// Steps through the stored pattern, compares each player press against it and
// reports a one-cycle pass/fail pulse per round, with a per-step response timeout.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | waiting for start; presses dropped
//   ST_FETCH    | address presented, pattern memory read in flight
//   ST_LOAD     | capture expected code, clear timeout counter
//   ST_WAIT_BTN | waiting for a press or timeout
//   ST_RESULT   | pass/fail pulse high, busy low; back to idle
module guess_checker
   import guess_checker_pkg::*;
#(
   parameter int IDX_W       = IDX_W_DEF,
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int TMO_W       = 26
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [IDX_W-1:0] i_seq_len,
   input  logic [3:0]       i_btn_pulse,
   output logic [IDX_W-1:0] o_mem_addr,
   input  logic [1:0]       i_mem_data,
   output logic             o_busy,
   output logic             o_pass,
   output logic             o_fail,
   output logic [IDX_W-1:0] o_step_idx,
   output logic [3:0]       o_last_btn
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_t           r_state,    w_state_nxt;
   logic [IDX_W-1:0] r_mem_addr, w_addr_nxt;
   logic [IDX_W-1:0] r_step_idx, w_step_nxt;
   logic [IDX_W-1:0] r_seq_len,  w_seq_nxt;
   logic [3:0]       r_last_btn, w_last_nxt;
   logic [1:0]       r_expected, w_exp_nxt;
   logic [TMO_W-1:0] r_tmo_cnt,  w_tmo_nxt;
   logic             r_busy,     w_busy_nxt;
   logic             r_pass,     w_pass_nxt;
   logic             r_fail,     w_fail_nxt;

   logic [1:0] w_code;
   logic       w_valid;
   logic       w_multi;

   guess_checker_btn_encoder u_btn_encoder (
      .i_onehot (i_btn_pulse),
      .o_code   (w_code),
      .o_valid  (w_valid),
      .o_multi  (w_multi)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state    <= ST_IDLE;
         r_mem_addr <= '0;
         r_step_idx <= '0;
         r_seq_len  <= '0;
         r_last_btn <= '0;
         r_expected <= BTN0;
         r_tmo_cnt  <= '0;
         r_busy     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mem_addr <= w_addr_nxt;
         r_step_idx <= w_step_nxt;
         r_seq_len  <= w_seq_nxt;
         r_last_btn <= w_last_nxt;
         r_expected <= w_exp_nxt;
         r_tmo_cnt  <= w_tmo_nxt;
         r_busy     <= w_busy_nxt;
         r_pass     <= w_pass_nxt;
         r_fail     <= w_fail_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_mem_addr;
      w_step_nxt  = r_step_idx;
      w_seq_nxt   = r_seq_len;
      w_last_nxt  = r_last_btn;
      w_exp_nxt   = r_expected;
      w_tmo_nxt   = r_tmo_cnt;
      w_busy_nxt  = r_busy;
      w_pass_nxt  = 1'b0;
      w_fail_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_seq_len != '0) begin
                  w_seq_nxt   = i_seq_len;
                  w_step_nxt  = '0;
                  w_addr_nxt  = '0;
                  w_last_nxt  = '0;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = ST_FETCH;
               end else begin
                  // Empty round is trivially won without ever going busy.
                  w_pass_nxt = 1'b1;
               end
            end
         end
         ST_FETCH: w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            w_exp_nxt   = i_mem_data;
            w_tmo_nxt   = '0;
            w_state_nxt = ST_WAIT_BTN;
         end
         ST_WAIT_BTN: begin
            // A press is checked before the timeout so a press on the expiry cycle wins.
            if (w_valid) begin
               w_last_nxt = i_btn_pulse;
               if (w_code != r_expected) begin
                  w_fail_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = ST_RESULT;
               end else if (r_step_idx == (r_seq_len - IDX_W'(1))) begin
                  w_pass_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = ST_RESULT;
               end else begin
                  w_step_nxt  = r_step_idx + IDX_W'(1);
                  w_addr_nxt  = r_mem_addr + IDX_W'(1);
                  w_state_nxt = ST_FETCH;
               end
            end else if (w_multi) begin
               w_fail_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_RESULT;
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_fail_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_RESULT;
            end else begin
               w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
            end
         end
         ST_RESULT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_mem_addr = r_mem_addr;
   assign o_step_idx = r_step_idx;
   assign o_last_btn = r_last_btn;
   assign o_busy     = r_busy;
   assign o_pass     = r_pass;
   assign o_fail     = r_fail;

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker with a synchronous-read pattern memory model.
module tb_guess_checker;

   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [IDX_W-1:0] seq_len = '0;
   logic [3:0]       btn_pulse = '0;
   logic [IDX_W-1:0] mem_addr;
   logic [1:0]       mem_data = '0;
   logic             busy, pass, fail;
   logic [IDX_W-1:0] step_idx;
   logic [3:0]       last_btn;

   logic [1:0] mem [0:15];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= mem[mem_addr];

   guess_checker #(.IDX_W(IDX_W), .TIMEOUT_CYC(8), .TMO_W(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_seq_len   (seq_len),
      .i_btn_pulse (btn_pulse),
      .o_mem_addr  (mem_addr),
      .i_mem_data  (mem_data),
      .o_busy      (busy),
      .o_pass      (pass),
      .o_fail      (fail),
      .o_step_idx  (step_idx),
      .o_last_btn  (last_btn)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] b);
      btn_pulse = b;
      tick();
      btn_pulse = '0;
   endtask

   task automatic do_start(input logic [IDX_W-1:0] len);
      seq_len = len;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 2'd0;
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;

      ticks(2);
      rst = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_pass", pass, 0);
      check("rst_fail", fail, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_step", step_idx, 0);
      check("rst_last", last_btn, 0);

      // Full correct round {2,0,3}
      do_start(3);
      check("t1_busy", busy, 1);
      check("t1_addr0", mem_addr, 0);
      ticks(2);
      press(4'b0100);
      check("t1_addr1", mem_addr, 1);
      check("t1_step1", step_idx, 1);
      check("t1_last1", last_btn, 4'b0100);
      ticks(2);
      press(4'b0001);
      check("t1_addr2", mem_addr, 2);
      check("t1_nopass", pass, 0);
      ticks(2);
      press(4'b1000);
      check("t1_pass", pass, 1);
      check("t1_fail", fail, 0);
      check("t1_busy_lo", busy, 0);
      check("t1_step", step_idx, 2);
      tick();
      check("t1_pass_end", pass, 0);
      check("t1_hold_step", step_idx, 2);

      // Wrong second button
      do_start(3);
      check("t2_last_clr", last_btn, 0);
      ticks(2);
      press(4'b0100);
      ticks(2);
      press(4'b0010);
      check("t2_fail", fail, 1);
      check("t2_pass", pass, 0);
      check("t2_step", step_idx, 1);
      check("t2_last", last_btn, 4'b0010);
      check("t2_busy", busy, 0);
      tick();
      check("t2_fail_end", fail, 0);

      // Multi-press
      do_start(3);
      ticks(2);
      press(4'b0100);
      ticks(2);
      press(4'b0101);
      check("t3_fail", fail, 1);
      check("t3_last", last_btn, 4'b0100);
      tick();

      // Timeout with no press
      do_start(3);
      ticks(2);
      ticks(7);
      check("t4_no_fail_yet", fail, 0);
      check("t4_busy", busy, 1);
      tick();
      check("t4_fail", fail, 1);
      check("t4_busy_lo", busy, 0);
      tick();

      // Correct press on the expiry cycle wins
      do_start(3);
      ticks(2);
      ticks(7);
      press(4'b0100);
      check("t4b_no_fail", fail, 0);
      check("t4b_step", step_idx, 1);
      check("t4b_addr", mem_addr, 1);

      // Press during FETCH dropped, start during WAIT_BTN ignored
      press(4'b0001);
      check("t5_fetch_step", step_idx, 1);
      check("t5_fetch_last", last_btn, 4'b0100);
      check("t5_fetch_fail", fail, 0);
      tick();
      do_start(5);
      check("t5_start_step", step_idx, 1);
      check("t5_start_addr", mem_addr, 1);
      check("t5_start_busy", busy, 1);
      check("t5_start_pass", pass, 0);

      // Mid-round reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_addr", mem_addr, 0);
      check("t5_rst_step", step_idx, 0);
      check("t5_rst_last", last_btn, 0);
      press(4'b0001);
      check("t5_idle_pass", pass, 0);
      check("t5_idle_fail", fail, 0);
      check("t5_idle_last", last_btn, 0);

      // Empty round
      do_start(0);
      check("t6_zero_pass", pass, 1);
      check("t6_zero_busy", busy, 0);
      tick();
      check("t6_zero_pass_end", pass, 0);
      check("t6_zero_busy2", busy, 0);

      // Longest round, no index wrap
      for (int i = 0; i < 15; i++) mem[i] = 2'(i % 4);
      do_start(15);
      ticks(2);
      for (int i = 0; i < 15; i++) begin
         logic [3:0] b;
         b = 4'b0001 << mem[i];
         press(b);
         if (i < 14) begin
            check("t6_long_step", step_idx, 32'(i + 1));
            check("t6_long_nopass", pass, 0);
            ticks(2);
         end else begin
            check("t6_long_pass", pass, 1);
            check("t6_long_fail", fail, 0);
            check("t6_long_final", step_idx, 14);
         end
      end
      tick();
      check("t6_long_pass_end", pass, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
